// File: rtl/hit_stretch_multi.sv
// hit_stretch_multi: N-channel hit-pulse stretcher.
// Each active-low raw hit is synchronised and falling-edge detected, then widened
// to a programmable active-low pulse (optional retrigger, post-pulse holdoff).
// Per-channel saturating hit counters and sticky miss flags feed slow control.
module hit_stretch_multi #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8,
    parameter int HCNT_W   = 16,
    parameter int SYNC_STG = 2
) (
    input  logic                     Clk_In,
    input  logic                     Rst_N,
    input  logic [N_CH-1:0]          In_Hit_N,
    input  logic [N_CH-1:0]          Ch_Enable,
    input  logic [CNT_W-1:0]         Cfg_Width,
    input  logic [CNT_W-1:0]         Cfg_Holdoff,
    input  logic                     Cfg_Retrig,
    input  logic                     Cnt_Clr,
    output logic [N_CH-1:0]          Out_Hit_N,
    output logic                     Out_Hit_Or_N,
    output logic [N_CH*HCNT_W-1:0]   Hit_Cnt,
    output logic [N_CH-1:0]          Miss_Flag
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [HCNT_W-1:0] HCNT_ONE = {{(HCNT_W-1){1'b0}}, 1'b1};

    logic [N_CH-1:0]  sync_r [SYNC_STG];
    logic [N_CH-1:0]  dly_r;
    logic [N_CH-1:0]  edge_s;
    logic [N_CH-1:0]  out_nx_s;
    logic [CNT_W-1:0] width_load_s;
    logic             or_r;

    // Synchroniser chain plus one delayed copy of its output for edge detection.
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            for (int i = 0; i < SYNC_STG; i++) begin
                sync_r[i] <= {N_CH{1'b1}};
            end
            dly_r <= {N_CH{1'b1}};
        end else begin
            sync_r[0] <= In_Hit_N;
            for (int i = 1; i < SYNC_STG; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            dly_r <= sync_r[SYNC_STG-1];
        end
    end

    // High-to-low transition of the synchronised hit, one cycle wide.
    assign edge_s = ~sync_r[SYNC_STG-1] & dly_r;

    // A programmed width of 0 behaves as 1, so the reload value is W-1 floored at 0.
    assign width_load_s = (Cfg_Width == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (Cfg_Width - CNT_ONE);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t            state_r, state_nx_s;
        logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
        logic [CNT_W-1:0]  hold_r, hold_nx_s;
        logic              accept_s, miss_s;
        logic              out_r;
        logic [HCNT_W-1:0] hcnt_r;
        logic              miss_r;

        // Next-state, counter and event decode for one channel.
        always_comb begin
            state_nx_s = state_r;
            cnt_nx_s   = cnt_r;
            hold_nx_s  = hold_r;
            accept_s   = 1'b0;
            miss_s     = 1'b0;
            if (!Ch_Enable[g]) begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (edge_s[g]) begin
                            state_nx_s = ST_STRETCH;
                            cnt_nx_s   = width_load_s;
                            hold_nx_s  = Cfg_Holdoff;
                            accept_s   = 1'b1;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end
                    ST_STRETCH: begin
                        if (edge_s[g] && Cfg_Retrig) begin
                            cnt_nx_s  = width_load_s;
                            hold_nx_s = Cfg_Holdoff;
                            accept_s  = 1'b1;
                        end else begin
                            miss_s = edge_s[g];
                            if (cnt_r == {CNT_W{1'b0}}) begin
                                if (hold_r != {CNT_W{1'b0}}) begin
                                    state_nx_s = ST_HOLDOFF;
                                    cnt_nx_s   = hold_r - CNT_ONE;
                                end else begin
                                    state_nx_s = ST_IDLE;
                                end
                            end else begin
                                cnt_nx_s = cnt_r - CNT_ONE;
                            end
                        end
                    end
                    ST_HOLDOFF: begin
                        miss_s = edge_s[g];
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            state_nx_s = ST_IDLE;
                        end else begin
                            cnt_nx_s = cnt_r - CNT_ONE;
                        end
                    end
                    default: begin
                        state_nx_s = ST_IDLE;
                        cnt_nx_s   = {CNT_W{1'b0}};
                    end
                endcase
            end
        end

        assign out_nx_s[g] = (state_nx_s != ST_STRETCH);

        // Channel state, counters and the stretched output flop.
        always_ff @(posedge Clk_In or negedge Rst_N) begin
            if (!Rst_N) begin
                state_r <= ST_IDLE;
                cnt_r   <= {CNT_W{1'b0}};
                hold_r  <= {CNT_W{1'b0}};
                out_r   <= 1'b1;
            end else begin
                state_r <= state_nx_s;
                cnt_r   <= cnt_nx_s;
                hold_r  <= hold_nx_s;
                out_r   <= out_nx_s[g];
            end
        end

        // Saturating hit counter and sticky miss flag; clear wins over history.
        always_ff @(posedge Clk_In or negedge Rst_N) begin
            if (!Rst_N) begin
                hcnt_r <= {HCNT_W{1'b0}};
                miss_r <= 1'b0;
            end else if (Cnt_Clr) begin
                hcnt_r <= accept_s ? HCNT_ONE : {HCNT_W{1'b0}};
                miss_r <= miss_s;
            end else begin
                if (accept_s && (hcnt_r != {HCNT_W{1'b1}})) begin
                    hcnt_r <= hcnt_r + HCNT_ONE;
                end
                miss_r <= miss_r | miss_s;
            end
        end

        assign Out_Hit_N[g]                 = out_r;
        assign Hit_Cnt[g*HCNT_W +: HCNT_W]  = hcnt_r;
        assign Miss_Flag[g]                 = miss_r;
    end

    // Combined output registered from the same next values as the channel outputs.
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            or_r <= 1'b1;
        end else begin
            or_r <= &out_nx_s;
        end
    end

    assign Out_Hit_Or_N = or_r;

endmodule

// File: tb/tb_hit_stretch_multi.sv
// Testbench for hit_stretch_multi: directed scenarios plus randomized traffic,
// every cycle compared against a remaining-cycles reference model.
module tb_hit_stretch_multi;
    localparam int N  = 4;
    localparam int CW = 8;
    localparam int HW = 16;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      in_hit_n = '1;
    logic [N-1:0]      ch_en = '1;
    logic [CW-1:0]     cfg_w = 8'd20;
    logic [CW-1:0]     cfg_h = 8'd0;
    logic              cfg_retrig = 1'b0;
    logic              cnt_clr = 1'b0;
    logic [N-1:0]      out_n, out_n_s;
    logic              or_n, or_n_s;
    logic [N*HW-1:0]   hcnt;
    logic [N*SW-1:0]   hcnt_s;
    logic [N-1:0]      miss, miss_s;

    always #5 clk = ~clk;

    hit_stretch_multi #(.N_CH(N), .CNT_W(CW), .HCNT_W(HW), .SYNC_STG(2)) u_dut (
        .Clk_In(clk), .Rst_N(rst_n), .In_Hit_N(in_hit_n), .Ch_Enable(ch_en),
        .Cfg_Width(cfg_w), .Cfg_Holdoff(cfg_h), .Cfg_Retrig(cfg_retrig), .Cnt_Clr(cnt_clr),
        .Out_Hit_N(out_n), .Out_Hit_Or_N(or_n), .Hit_Cnt(hcnt), .Miss_Flag(miss));

    // Narrow-counter instance to reach saturation in few hits.
    hit_stretch_multi #(.N_CH(N), .CNT_W(CW), .HCNT_W(SW), .SYNC_STG(2)) u_sat (
        .Clk_In(clk), .Rst_N(rst_n), .In_Hit_N(in_hit_n), .Ch_Enable(ch_en),
        .Cfg_Width(cfg_w), .Cfg_Holdoff(cfg_h), .Cfg_Retrig(cfg_retrig), .Cnt_Clr(cnt_clr),
        .Out_Hit_N(out_n_s), .Out_Hit_Or_N(or_n_s), .Hit_Cnt(hcnt_s), .Miss_Flag(miss_s));

    int vec_cnt = 0;
    int err_cnt = 0;

    // reference model: remaining low cycles / remaining dead cycles per channel
    int     low_left [N];
    int     dead_left[N];
    int     h_lat    [N];
    int     m_cnt    [N];
    int     m_sat    [N];
    bit     m_miss   [N];
    logic [N-1:0] p1, p2, p3;
    int     low0, low_or;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            low_left[c] = 0; dead_left[c] = 0; h_lat[c] = 0;
            m_cnt[c] = 0; m_sat[c] = 0; m_miss[c] = 1'b0;
        end
        p1 = '1; p2 = '1; p3 = '1;
    endtask

    task automatic model_edge();
        int w_eff;
        bit e, acc, ms;
        w_eff = (cfg_w == 8'd0) ? 1 : int'(cfg_w);
        for (int c = 0; c < N; c++) begin
            e = !p2[c] && p3[c];
            acc = 1'b0; ms = 1'b0;
            if (!ch_en[c]) begin
                low_left[c] = 0; dead_left[c] = 0;
            end else if (low_left[c] > 0) begin
                if (e && cfg_retrig) begin
                    low_left[c] = w_eff; h_lat[c] = int'(cfg_h); acc = 1'b1;
                end else begin
                    ms = e;
                    low_left[c]--;
                    if (low_left[c] == 0) dead_left[c] = h_lat[c];
                end
            end else if (dead_left[c] > 0) begin
                ms = e;
                dead_left[c]--;
            end else if (e) begin
                low_left[c] = w_eff; h_lat[c] = int'(cfg_h); acc = 1'b1;
            end
            if (cnt_clr) begin
                m_cnt[c] = acc ? 1 : 0;
                m_sat[c] = acc ? 1 : 0;
                m_miss[c] = ms;
            end else begin
                if (acc) begin
                    m_cnt[c] = (m_cnt[c] + 1 > 65535) ? 65535 : m_cnt[c] + 1;
                    m_sat[c] = (m_sat[c] + 1 > 7) ? 7 : m_sat[c] + 1;
                end
                m_miss[c] = m_miss[c] | ms;
            end
        end
        p3 = p2; p2 = p1; p1 = in_hit_n;
    endtask

    task automatic step();
        bit any_low;
        @(posedge clk);
        model_edge();
        #1;
        any_low = 1'b0;
        for (int c = 0; c < N; c++) begin
            check_val($sformatf("out%0d", c), out_n[c], (low_left[c] == 0));
            check_val($sformatf("hcnt%0d", c), hcnt[c*HW +: HW], m_cnt[c]);
            check_val($sformatf("satcnt%0d", c), hcnt_s[c*SW +: SW], m_sat[c]);
            check_val($sformatf("miss%0d", c), miss[c], m_miss[c]);
            if (low_left[c] > 0) any_low = 1'b1;
        end
        check_val("or_n", or_n, !any_low);
        if (!out_n[0]) low0++;
        if (!or_n) low_or++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // drive channel mask low for lo cycles then high for hi cycles
    task automatic pulse(input logic [N-1:0] mask, input int lo, input int hi);
        in_hit_n = in_hit_n & ~mask;
        steps(lo);
        in_hit_n = in_hit_n | mask;
        steps(hi);
    endtask

    task automatic clear_counts();
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        low0 = 0; low_or = 0;
    endtask

    initial begin
        model_reset();
        low0 = 0; low_or = 0;
        #12;
        check_val("rst_out", out_n, 4'hF);
        check_val("rst_or", or_n, 1'b1);
        check_val("rst_hcnt", hcnt, 0);
        check_val("rst_miss", miss, 0);
        @(negedge clk);
        rst_n = 1'b1;
        steps(5);

        // single hit, W=20, H=0
        clear_counts();
        pulse(4'b0001, 4, 30);
        check_val("single_w", low0, 20);
        check_val("single_cnt", hcnt[HW-1:0], 1);

        // retrigger 10 cycles after first edge
        cfg_retrig = 1'b1;
        clear_counts();
        pulse(4'b0001, 4, 6);
        pulse(4'b0001, 4, 40);
        check_val("retrig_w", low0, 30);
        check_val("retrig_cnt", hcnt[HW-1:0], 2);

        // no retrigger, holdoff 8, edges at +10 and +25
        cfg_retrig = 1'b0; cfg_h = 8'd8;
        clear_counts();
        pulse(4'b0001, 4, 6);
        pulse(4'b0001, 4, 11);
        pulse(4'b0001, 4, 40);
        check_val("hold_w", low0, 20);
        check_val("hold_cnt", hcnt[HW-1:0], 1);
        check_val("hold_miss", miss[0], 1'b1);

        // W=0 behaves as 1
        cfg_w = 8'd0; cfg_h = 8'd0;
        clear_counts();
        pulse(4'b0001, 4, 10);
        check_val("w0_w", low0, 1);

        // edge on last holdoff cycle dropped (W=2,H=3, edges 5 apart)
        cfg_w = 8'd2; cfg_h = 8'd3;
        clear_counts();
        pulse(4'b0001, 3, 2);
        pulse(4'b0001, 3, 20);
        check_val("lasthold_w", low0, 2);
        check_val("lasthold_miss", miss[0], 1'b1);
        check_val("lasthold_cnt", hcnt[HW-1:0], 1);

        // edge one cycle later (6 apart) accepted
        clear_counts();
        pulse(4'b0001, 3, 3);
        pulse(4'b0001, 3, 20);
        check_val("afterhold_w", low0, 4);
        check_val("afterhold_miss", miss[0], 1'b0);
        check_val("afterhold_cnt", hcnt[HW-1:0], 2);

        // all channels together
        cfg_w = 8'd20; cfg_h = 8'd0;
        clear_counts();
        pulse(4'b1111, 4, 30);
        check_val("multi_or", low_or, 20);
        for (int c = 0; c < N; c++) check_val($sformatf("multi_cnt%0d", c), hcnt[c*HW +: HW], 1);

        // disable channel 2 mid-pulse
        pulse(4'b1111, 4, 6);
        ch_en[2] = 1'b0;
        step();
        check_val("en_drop", out_n[2], 1'b1);
        steps(20);
        ch_en[2] = 1'b1;
        steps(5);

        // clear coincident with accept
        in_hit_n[0] = 1'b0;
        step(); step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        in_hit_n[0] = 1'b1;
        check_val("clr_acc", hcnt[HW-1:0], 1);
        steps(25);

        // saturation on the narrow instance
        cfg_w = 8'd1;
        for (int i = 0; i < 10; i++) pulse(4'b0001, 2, 3);
        check_val("sat", hcnt_s[SW-1:0], 7);

        // reset mid-stretch
        cfg_w = 8'd20;
        pulse(4'b0001, 4, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_out", out_n, 4'hF);
        check_val("rst_mid_or", or_n, 1'b1);
        check_val("rst_mid_cnt", hcnt, 0);
        check_val("rst_mid_miss", miss, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        low0 = 0;
        steps(30);
        check_val("rst_no_edge", low0, 0);

        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 9) == 0) in_hit_n[c] = ~in_hit_n[c];
                if (ch_en[c]) begin
                    if ($urandom_range(0, 299) == 0) ch_en[c] = 1'b0;
                end else begin
                    if ($urandom_range(0, 9) == 0) ch_en[c] = 1'b1;
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                cfg_w = 8'($urandom_range(0, 12));
                cfg_h = 8'($urandom_range(0, 6));
                cfg_retrig = 1'($urandom_range(0, 1));
            end
            cnt_clr = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
